// File: rtl/demux_seq_pkg.sv
// Shared types and constants for the demux channel sequencer and its
// round-robin channel picker.
package demux_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } dmx_state_t;

    localparam int CH_NUM = 4;
    localparam int CNT_W  = 8;

    typedef logic [1:0] sel_t;

endpackage

// File: rtl/demux_channel_sequencer_rr_pick.sv
// Round-robin priority scan: returns the first enabled channel at or after
// ptr, scanning upward and wrapping 3 -> 0. found is low when no channel
// is enabled, in which case sel is don't-care (driven to ptr).
module rr_pick
    import demux_seq_pkg::*;
(
    input  logic [1:0]        ptr,
    input  logic [CH_NUM-1:0] mask,
    output logic [1:0]        sel,
    output logic              found
);

    sel_t idx;

    // Scan the four channels starting at ptr; first enabled one wins.
    always_comb begin
        sel   = ptr;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            idx = ptr + 2'(i);
            if (!found && mask[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_channel_sequencer.sv
// Sequential front end for the 1-to-4 demux. Accepts single bits over a
// valid/ready handshake, assigns each to the next enabled channel in
// round-robin order, holds it on dmx_a/dmx_s for HOLD_CYCLES cycles, then
// inserts one guard cycle before accepting the next bit.
//
// Handshake: a bit transfers on a rising edge where in_valid && in_ready;
// in_ready is high only in IDLE with at least one channel enabled, and
// upstream keeps in_valid/in_data stable until that edge.
//
// Optional build macro: DMX_STATS_EN adds the ch_cnt port with per-channel
// saturating delivered-bit counters.
module demux_channel_sequencer
    import demux_seq_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1   // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_data,
    output logic        in_ready,
    input  logic [3:0]  ch_mask,
    output logic        dmx_a,
    output logic [1:0]  dmx_s,
    output logic        dmx_valid,
    output logic        busy,
    output logic [1:0]  dbg_state
`ifdef DMX_STATS_EN
    ,
    output logic [CH_NUM*CNT_W-1:0] ch_cnt
`endif
);

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    dmx_state_t state_q, state_d;
    sel_t       ptr_q, ptr_d;
    sel_t       sel_q, sel_d;
    logic [3:0] hold_q, hold_d;
    logic       dmx_a_q, dmx_a_d;
    sel_t       dmx_s_q, dmx_s_d;
    logic       dmx_valid_q, dmx_valid_d;
    logic       busy_q, busy_d;

    sel_t       pick_sel;
    logic       pick_found;
    logic       accept;

    rr_pick u_rr_pick (
        .ptr   (ptr_q),
        .mask  (ch_mask),
        .sel   (pick_sel),
        .found (pick_found)
    );

    // Ready depends on mask and state only, so it is valid even during reset.
    assign in_ready = (state_q == IDLE) && pick_found;
    assign accept   = in_valid && in_ready;

    // Next-state and next-output computation for the IDLE/DRIVE/GAP sequence.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        hold_d      = hold_q;
        dmx_a_d     = dmx_a_q;
        dmx_s_d     = dmx_s_q;
        dmx_valid_d = dmx_valid_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = DRIVE;
                    sel_d       = pick_sel;
                    hold_d      = HOLD_LOAD;
                    dmx_a_d     = in_data;
                    dmx_s_d     = pick_sel;
                    dmx_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            DRIVE: begin
                if (hold_q == 4'd0) begin
                    // Guard cycle: select stays on sel, data forced low.
                    state_d     = GAP;
                    dmx_a_d     = 1'b0;
                    dmx_valid_d = 1'b0;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            GAP: begin
                state_d = IDLE;
                ptr_d   = sel_q + 2'd1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d     = IDLE;
                dmx_a_d     = 1'b0;
                dmx_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs; reset clears them without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            hold_q      <= '0;
            dmx_a_q     <= 1'b0;
            dmx_s_q     <= '0;
            dmx_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            hold_q      <= hold_d;
            dmx_a_q     <= dmx_a_d;
            dmx_s_q     <= dmx_s_d;
            dmx_valid_q <= dmx_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign dmx_a     = dmx_a_q;
    assign dmx_s     = dmx_s_q;
    assign dmx_valid = dmx_valid_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

`ifdef DMX_STATS_EN
    logic             deliver;
    logic [CNT_W-1:0] ch_cnt_q [CH_NUM];
    logic [CNT_W-1:0] ch_cnt_d [CH_NUM];

    // A bit counts as delivered on the DRIVE -> GAP edge.
    assign deliver = (state_q == DRIVE) && (hold_q == 4'd0);

    // Saturating per-channel increment for the channel being delivered.
    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            ch_cnt_d[i] = ch_cnt_q[i];
            if (deliver && (sel_q == 2'(i)) && (ch_cnt_q[i] != {CNT_W{1'b1}})) begin
                ch_cnt_d[i] = ch_cnt_q[i] + 1'b1;
            end
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH_NUM; i++) begin
                ch_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                ch_cnt_q[i] <= ch_cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_cnt_out
        assign ch_cnt[g*CNT_W +: CNT_W] = ch_cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_demux_channel_sequencer.sv
// Bench for demux_channel_sequencer: two instances (hold 1 and hold 3)
// share clock, reset and mask; in_valid is steered to one of them.
`timescale 1ns/1ps
module tb_demux_channel_sequencer;
    import demux_seq_pkg::*;

    localparam int H_A = 1;
    localparam int H_B = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       in_valid, in_data, use_b;
    logic [3:0] ch_mask;

    logic       rdy_a, a_a, vld_a, busy_a;
    logic [1:0] s_a, st_a;
    logic       rdy_b, a_b, vld_b, busy_b;
    logic [1:0] s_b, st_b;
`ifdef DMX_STATS_EN
    logic [31:0] cnt_a, cnt_b;
`endif

    demux_channel_sequencer #(.HOLD_CYCLES(H_A)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & ~use_b),
        .in_data   (in_data),
        .in_ready  (rdy_a),
        .ch_mask   (ch_mask),
        .dmx_a     (a_a),
        .dmx_s     (s_a),
        .dmx_valid (vld_a),
        .busy      (busy_a),
        .dbg_state (st_a)
`ifdef DMX_STATS_EN
        ,
        .ch_cnt    (cnt_a)
`endif
    );

    demux_channel_sequencer #(.HOLD_CYCLES(H_B)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & use_b),
        .in_data   (in_data),
        .in_ready  (rdy_b),
        .ch_mask   (ch_mask),
        .dmx_a     (a_b),
        .dmx_s     (s_b),
        .dmx_valid (vld_b),
        .busy      (busy_b),
        .dbg_state (st_b)
`ifdef DMX_STATS_EN
        ,
        .ch_cnt    (cnt_b)
`endif
    );

    // Observed outputs of whichever instance is under test.
    logic       o_ready, o_a, o_vld, o_busy;
    logic [1:0] o_s;
    assign o_ready = use_b ? rdy_b  : rdy_a;
    assign o_a     = use_b ? a_b    : a_a;
    assign o_vld   = use_b ? vld_b  : vld_a;
    assign o_busy  = use_b ? busy_b : busy_a;
    assign o_s     = use_b ? s_b    : s_a;

    // ---------------- scoreboard / reference model ----------------
    int         n_checks = 0;
    int         n_errors = 0;
    logic [2:0] exp_q[$];          // {data, channel} per accepted bit
    int         model_ptr [2];     // round-robin pointer per instance
    int         deliv_cnt [4];     // bits delivered per channel on dut_a

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // First enabled channel at or after the pointer, wrapping 3 -> 0.
    function automatic int model_pick(input int di, input logic [3:0] m);
        for (int i = 0; i < 4; i++) begin
            int c;
            c = (model_ptr[di] + i) % 4;
            if (m[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        model_ptr[0] = 0;
        model_ptr[1] = 0;
        for (int i = 0; i < 4; i++) deliv_cnt[i] = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    // ---------------- driver ----------------
    // Called at a negedge with the instance idle. Offers one bit with mask m,
    // switches the mask to m_after right after acceptance, and checks the
    // full drive / guard / idle sequence against the model.
    task automatic send_bit(input logic d, input logic [3:0] m, input logic [3:0] m_after);
        int         di, h, waited, c;
        logic [2:0] e;
        di = use_b ? 1 : 0;
        h  = use_b ? H_B : H_A;
        in_valid = 1'b1;
        in_data  = d;
        ch_mask  = m;
        #1;
        waited = 0;
        while (!o_ready && waited < 8) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check_eq("ready_before_accept", 32'(o_ready), 32'd1);
        if (!o_ready) begin
            in_valid = 1'b0;
            return;
        end
        c = model_pick(di, m);
        exp_q.push_back({d, 2'(c)});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 1'($urandom_range(0, 1));
        ch_mask  = m_after;
        e = exp_q.pop_front();
        for (int k = 0; k < h; k++) begin
            @(negedge clk);
            check_eq("drive_valid", 32'(o_vld), 32'd1);
            check_eq("drive_a", 32'(o_a), 32'(e[2]));
            check_eq("drive_s", 32'(o_s), 32'(e[1:0]));
            check_eq("drive_busy", 32'(o_busy), 32'd1);
            check_eq("drive_ready", 32'(o_ready), 32'd0);
        end
        @(negedge clk);
        check_eq("gap_valid", 32'(o_vld), 32'd0);
        check_eq("gap_a", 32'(o_a), 32'd0);
        check_eq("gap_s", 32'(o_s), 32'(e[1:0]));
        check_eq("gap_busy", 32'(o_busy), 32'd1);
        check_eq("gap_ready", 32'(o_ready), 32'd0);
        model_ptr[di] = (c + 1) % 4;
        if (di == 0) deliv_cnt[c]++;
        @(negedge clk);
        check_eq("idle_valid", 32'(o_vld), 32'd0);
        check_eq("idle_busy", 32'(o_busy), 32'd0);
        check_eq("idle_ready", 32'(o_ready), 32'(|m_after));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] m, ma;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 1'b0;
        ch_mask  = 4'b1111;
        use_b    = 1'b0;
        model_reset();

        // Reset values and in_ready during reset.
        #1;
        check_eq("rst_valid", 32'(vld_a), 32'd0);
        check_eq("rst_a", 32'(a_a), 32'd0);
        check_eq("rst_s", 32'(s_a), 32'd0);
        check_eq("rst_busy", 32'(busy_a), 32'd0);
        check_eq("rst_state", 32'(st_a), 32'(IDLE));
        check_eq("rst_ready_mask", 32'(rdy_a), 32'd1);
        ch_mask = 4'b0000;
        #1;
        check_eq("rst_ready_nomask", 32'(rdy_a), 32'd0);
        ch_mask = 4'b1111;
`ifdef DMX_STATS_EN
        check_eq("rst_cnt", cnt_a, 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Full mask, hold 1: channels 0,1,2,3 in turn.
        send_bit(1'b1, 4'b1111, 4'b1111);
        send_bit(1'b0, 4'b1111, 4'b1111);
        send_bit(1'b1, 4'b1111, 4'b1111);
        send_bit(1'b1, 4'b1111, 4'b1111);

        // Mask 1010: only channels 1 and 3.
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 4'b1010, 4'b1010);

        // Empty mask stalls the block even with in_valid held high.
        in_valid = 1'b1;
        in_data  = 1'b1;
        ch_mask  = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq("nomask_ready", 32'(o_ready), 32'd0);
            check_eq("nomask_busy", 32'(o_busy), 32'd0);
            check_eq("nomask_valid", 32'(o_vld), 32'd0);
            @(negedge clk);
        end
        send_bit(1'b1, 4'b0100, 4'b0100);

        // Mask change while a bit is in flight.
        send_bit(1'b1, 4'b1111, 4'b0001);
        send_bit(1'b0, 4'b0001, 4'b0001);

        // Hold of 3 cycles on the second instance.
        use_b = 1'b1;
        send_bit(1'b1, 4'b1111, 4'b1111);

        // Reset asserted between edges while driving.
        in_valid = 1'b1;
        in_data  = 1'b1;
        ch_mask  = 4'b1000;
        #1;
        check_eq("rstmid_ready", 32'(o_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("rstmid_pre_valid", 32'(o_vld), 32'd1);
        check_eq("rstmid_pre_s", 32'(o_s), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rstmid_valid", 32'(o_vld), 32'd0);
        check_eq("rstmid_a", 32'(o_a), 32'd0);
        check_eq("rstmid_s", 32'(o_s), 32'd0);
        check_eq("rstmid_busy", 32'(o_busy), 32'd0);
        check_eq("rstmid_ready_in_rst", 32'(o_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        use_b = 1'b0;

        // Randomized traffic with random masks and occasional stalls.
        for (int n = 0; n < 40; n++) begin
            m = 4'($urandom_range(0, 15));
            if (m == 4'b0000) begin
                in_valid = 1'b1;
                ch_mask  = 4'b0000;
                for (int k = 0; k < 3; k++) begin
                    #1;
                    check_eq("rand_stall_ready", 32'(o_ready), 32'd0);
                    check_eq("rand_stall_busy", 32'(o_busy), 32'd0);
                    @(negedge clk);
                end
                m = 4'($urandom_range(1, 15));
            end
            ma = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : m;
            send_bit(1'($urandom_range(0, 1)), m, ma);
        end

`ifdef DMX_STATS_EN
        for (int i = 0; i < 4; i++) begin
            check_eq("rand_cnt", 32'(cnt_a[i*8 +: 8]), 32'((deliv_cnt[i] > 255) ? 255 : deliv_cnt[i]));
        end
        // Saturation: 300 bits on channel 0 only.
        do_reset();
        for (int n = 0; n < 300; n++) send_bit(1'($urandom_range(0, 1)), 4'b0001, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            check_eq("sat_cnt", 32'(cnt_a[i*8 +: 8]), 32'((deliv_cnt[i] > 255) ? 255 : deliv_cnt[i]));
        end
        check_eq("sat_cnt0", 32'(cnt_a[7:0]), 32'd255);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
